// File: rtl/instr_byte_queue_pkg.sv
// Shared decoder-side types and defaults for the byte-granular instruction queue.
// The window type is the same one the opcode decoder takes as its byte input.
package instr_byte_queue_pkg;

    localparam int MAX_INSTR_BYTES     = 15;
    localparam int FETCH_BYTES_DEFAULT = 8;
    localparam int DEPTH_BYTES_DEFAULT = 32;

    // Byte 0 (the oldest byte) occupies bits [0:7].
    typedef logic [0:MAX_INSTR_BYTES*8-1] instr_window_t;

endpackage

// File: rtl/instr_byte_queue_if.sv
// Fetch-side push handshake and decoder-side window/consume bundle.
// The master side is fetch plus decoder; the slave side is the queue itself.
interface instr_byte_queue_if
    import instr_byte_queue_pkg::*;
#(
    parameter int FETCH_BYTES = FETCH_BYTES_DEFAULT,
    parameter int DEPTH_BYTES = DEPTH_BYTES_DEFAULT
);
    localparam int CNT_W = $clog2(DEPTH_BYTES) + 1;

    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [0:FETCH_BYTES*8-1] in_data;
    instr_window_t            win_bytes;
    logic [3:0]               win_count;
    logic                     consume_valid;
    logic [3:0]               consume_len;
    logic                     consume_err;
    logic [CNT_W-1:0]         occupancy;

    modport master (
        output flush, in_valid, in_data, consume_valid, consume_len,
        input  in_ready, win_bytes, win_count, consume_err, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, consume_valid, consume_len,
        output in_ready, win_bytes, win_count, consume_err, occupancy
    );

endinterface

// File: rtl/instr_byte_queue.sv
// Circular byte buffer between fetch and the opcode decoder: accepts whole fetch
// blocks, exposes the oldest bytes as a window, retires a variable count per cycle.
module instr_byte_queue
    import instr_byte_queue_pkg::*;
#(
    parameter int FETCH_BYTES = FETCH_BYTES_DEFAULT,
    parameter int DEPTH_BYTES = DEPTH_BYTES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_byte_queue_if.slave  bus
);
    localparam int PTR_W        = $clog2(DEPTH_BYTES);
    localparam int CNT_W        = PTR_W + 1;
    localparam int WINDOW_BYTES = MAX_INSTR_BYTES;

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             consume_err_reg;
    logic [7:0]       storage [DEPTH_BYTES];

    logic [CNT_W-1:0] free_bytes;
    logic             write_en;
    logic             consume_legal;
    logic             consume_illegal;
    logic [3:0]       win_count;
    logic [7:0]       win_arr [WINDOW_BYTES];

    // in_ready looks only at registered count and flush, never at consume_*.
    assign free_bytes = CNT_W'(DEPTH_BYTES) - count_reg;
    assign bus.in_ready = reset_n && !bus.flush && (free_bytes >= CNT_W'(FETCH_BYTES));
    assign write_en = bus.in_valid && bus.in_ready;

    assign win_count = (count_reg >= CNT_W'(WINDOW_BYTES)) ? 4'(WINDOW_BYTES) : count_reg[3:0];

    assign consume_legal   = bus.consume_valid && (bus.consume_len != 4'd0)
                             && (bus.consume_len <= win_count);
    assign consume_illegal = bus.consume_valid && !consume_legal && !bus.flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
            consume_err_reg <= 1'b0;
        end else if (bus.flush) begin
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
            consume_err_reg <= 1'b0;
        end else begin
            if (consume_legal) begin
                head_reg <= head_reg + PTR_W'(bus.consume_len);
            end
            if (write_en) begin
                tail_reg <= tail_reg + PTR_W'(FETCH_BYTES);
            end
            count_reg <= count_reg
                         + (write_en      ? CNT_W'(FETCH_BYTES)     : '0)
                         - (consume_legal ? CNT_W'(bus.consume_len) : '0);
            consume_err_reg <= consume_illegal;
        end
    end

    // Byte storage carries no reset; count alone decides which bytes are live.
    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int i = 0; i < FETCH_BYTES; i++) begin
                storage[tail_reg + PTR_W'(i)] <= bus.in_data[i*8 +: 8];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WINDOW_BYTES; gi++) begin : g_win
            logic [PTR_W-1:0] rd_idx;
            assign rd_idx      = head_reg + PTR_W'(gi);
            assign win_arr[gi] = (4'(gi) < win_count) ? storage[rd_idx] : 8'h00;
        end
    endgenerate

    always_comb begin
        bus.win_bytes = '0;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            bus.win_bytes[i*8 +: 8] = win_arr[i];
        end
    end

    assign bus.win_count   = win_count;
    assign bus.consume_err = consume_err_reg;
    assign bus.occupancy   = count_reg;

endmodule
